slot_run_scheduler: RTL and testbench

Top-level run scheduler that drives the `ap_ctrl` handshake of every floorplanned slot in a partitioned kernel. It launches all enabled slots together and waits until each has reported done. It then relaunches them for a programmed number of back-to-back iterations before raising the kernel-level `ap_done`/`ap_ready`. It sits in the top FSM module, between the host control interface and the per-slot `ap_start`/`ap_ready`/`ap_done`/`ap_idle` ports.

---
 rtl/slot_sched_pkg.sv | 22 ++
 rtl/slot_ctrl_fsm.sv | 45 ++++
 rtl/slot_run_scheduler.sv | 138 +++++++++++++
 tb/tb_slot_run_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_sched_pkg.sv
// Shared types and default sizing for the slot run scheduler.
package slot_sched_pkg;

    typedef enum logic [1:0] {
        TOP_IDLE   = 2'b00,
        TOP_RUN    = 2'b01,
        TOP_FINISH = 2'b10
    } top_state_t;

    // Encoding is visible on debug taps, so it is pinned explicitly.
    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'b00,
        SLOT_START = 2'b01,
        SLOT_RUN   = 2'b11,
        SLOT_DONE  = 2'b10
    } slot_state_t;

    localparam int DEF_NUM_SLOTS      = 3;
    localparam int DEF_CNT_W          = 32;
    localparam int DEF_TIMEOUT_CYCLES = 1048576;

endpackage

// File: rtl/slot_ctrl_fsm.sv
// One slot's ap_ctrl handshake tracker: START until ready, RUN until done,
// then parks in DONE until the top relaunches or finishes.
module slot_ctrl_fsm
    import slot_sched_pkg::*;
(
    input  logic ap_clk,
    input  logic ap_rst,
    input  logic launch,
    input  logic relaunch,
    input  logic clear,
    input  logic abort,
    input  logic ready,
    input  logic done,
    output logic ap_start,
    output logic is_done
);

    slot_state_t state;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= SLOT_IDLE;
        end else if (abort) begin
            state <= SLOT_IDLE;
        end else begin
            case (state)
                SLOT_IDLE:  if (launch) state <= SLOT_START;
                SLOT_START: begin
                    if (ready && done) state <= SLOT_DONE;
                    else if (ready)    state <= SLOT_RUN;
                end
                SLOT_RUN:   if (done) state <= SLOT_DONE;
                SLOT_DONE: begin
                    if (relaunch)   state <= SLOT_START;
                    else if (clear) state <= SLOT_IDLE;
                end
                default:    state <= SLOT_IDLE;
            endcase
        end
    end

    assign ap_start = (state == SLOT_START);
    assign is_done  = (state == SLOT_DONE);

endmodule

// File: rtl/slot_run_scheduler.sv
// Kernel-level run scheduler over NUM_SLOTS slot handshakes.
// Optional per-iteration watchdog: define SLOT_SCHED_WATCHDOG_EN.
module slot_run_scheduler
    import slot_sched_pkg::*;
#(
    parameter int NUM_SLOTS      = DEF_NUM_SLOTS,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_start,
    output logic                 ap_ready,
    output logic                 ap_done,
    output logic                 ap_idle,
    input  logic [CNT_W-1:0]     run_count,
    input  logic [NUM_SLOTS-1:0] slot_mask,
    output logic [NUM_SLOTS-1:0] slot_ap_start,
    input  logic [NUM_SLOTS-1:0] slot_ap_ready,
    input  logic [NUM_SLOTS-1:0] slot_ap_done,
    input  logic [NUM_SLOTS-1:0] slot_ap_idle,
    output logic [CNT_W-1:0]     runs_done,
    output logic                 timeout_err
);

    top_state_t           state;
    logic [CNT_W-1:0]     count_q;
    logic [NUM_SLOTS-1:0] mask_q;
    logic [NUM_SLOTS-1:0] slot_is_done;
    logic [CNT_W:0]       runs_next;
    logic                 go;
    logic                 all_done;
    logic                 last_iter;
    logic                 relaunch;
    logic                 timeout;
    logic                 unused_slot_idle;

    assign unused_slot_idle = ^slot_ap_idle;

    assign go        = (state == TOP_IDLE) && ap_start
                       && (run_count != '0) && (slot_mask != '0);
    // Disabled slots never leave IDLE, so they are treated as already done.
    assign all_done  = (state == TOP_RUN) && (&(slot_is_done | ~mask_q));
    assign runs_next = {1'b0, runs_done} + {{CNT_W{1'b0}}, 1'b1};
    assign last_iter = (runs_next >= {1'b0, count_q});
    assign relaunch  = all_done && !last_iter;
    assign ap_ready  = ap_done;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= TOP_IDLE;
            count_q   <= '0;
            mask_q    <= '0;
            runs_done <= '0;
            ap_done   <= 1'b0;
            ap_idle   <= 1'b1;
        end else begin
            ap_done <= 1'b0;
            case (state)
                TOP_IDLE: begin
                    if (ap_start) begin
                        count_q   <= run_count;
                        mask_q    <= slot_mask;
                        runs_done <= '0;
                        ap_idle   <= 1'b0;
                        if (go) begin
                            state <= TOP_RUN;
                        end else begin
                            state   <= TOP_FINISH;
                            ap_done <= 1'b1;
                        end
                    end
                end
                TOP_RUN: begin
                    if (all_done) begin
                        if (runs_done != '1) runs_done <= runs_next[CNT_W-1:0];
                        if (last_iter) begin
                            state   <= TOP_FINISH;
                            ap_done <= 1'b1;
                        end
                    end else if (timeout) begin
                        state   <= TOP_FINISH;
                        ap_done <= 1'b1;
                    end
                end
                TOP_FINISH: begin
                    state   <= TOP_IDLE;
                    ap_idle <= 1'b1;
                end
                default: begin
                    state   <= TOP_IDLE;
                    ap_idle <= 1'b1;
                end
            endcase
        end
    end

`ifdef SLOT_SCHED_WATCHDOG_EN
    logic [31:0] wd_cnt;

    assign timeout = (state == TOP_RUN) && !all_done
                     && (wd_cnt >= 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (go || relaunch)      wd_cnt <= '0;
            else if (state == TOP_RUN) wd_cnt <= wd_cnt + 32'd1;
            if (timeout)                              timeout_err <= 1'b1;
            else if ((state == TOP_IDLE) && ap_start) timeout_err <= 1'b0;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        slot_ctrl_fsm u_slot (
            .ap_clk   (ap_clk),
            .ap_rst   (ap_rst),
            .launch   (go && slot_mask[i]),
            .relaunch (relaunch && mask_q[i]),
            .clear    (state == TOP_FINISH),
            .abort    (timeout),
            .ready    (slot_ap_ready[i]),
            .done     (slot_ap_done[i]),
            .ap_start (slot_ap_start[i]),
            .is_done  (slot_is_done[i])
        );
    end

endmodule

// File: tb/tb_slot_run_scheduler.sv
// Directed bench for slot_run_scheduler: cycle table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_slot_run_scheduler;
    localparam int NS         = 3;
    localparam int CW         = 32;
    localparam int TB_TIMEOUT = 16;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          ap_start;
    logic          ap_ready;
    logic          ap_done;
    logic          ap_idle;
    logic [CW-1:0] run_count;
    logic [NS-1:0] slot_mask;
    logic [NS-1:0] slot_ap_start;
    logic [NS-1:0] slot_ap_ready;
    logic [NS-1:0] slot_ap_done;
    logic [NS-1:0] slot_ap_idle;
    logic [CW-1:0] runs_done;
    logic          timeout_err;

    always #5 ap_clk = ~ap_clk;

    slot_run_scheduler #(
        .NUM_SLOTS      (NS),
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .run_count     (run_count),
        .slot_mask     (slot_mask),
        .slot_ap_start (slot_ap_start),
        .slot_ap_ready (slot_ap_ready),
        .slot_ap_done  (slot_ap_done),
        .slot_ap_idle  (slot_ap_idle),
        .runs_done     (runs_done),
        .timeout_err   (timeout_err)
    );

    typedef struct {
        logic          start;
        logic [NS-1:0] rdy;
        logic [NS-1:0] dn;
        logic [NS-1:0] e_sstart;
        logic          e_done;
        logic          e_idle;
        logic [CW-1:0] e_runs;
    } vec_t;

    vec_t tbl [9];

    int            nchecks = 0;
    int            nerrs   = 0;
    int            cyc;
    int            start_cnt    [NS];
    int            second_start [NS];
    int            lat          [NS];
    int            rcnt         [NS];
    int            done_cyc;
    int            ready_mis;
    logic [CW-1:0] runs_at_done;
    bit            auto_resp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: observe DUT at the falling edge, then drive slot responses.
    task automatic tick();
        @(negedge ap_clk);
        cyc++;
        for (int i = 0; i < NS; i++) begin
            if (slot_ap_start[i]) begin
                start_cnt[i]++;
                if (start_cnt[i] == 2) second_start[i] = cyc;
            end
        end
        if (ap_done && done_cyc < 0) begin
            done_cyc     = cyc;
            runs_at_done = runs_done;
        end
        if (ap_ready !== ap_done) ready_mis++;
        if (auto_resp) begin
            for (int i = 0; i < NS; i++) begin
                if (slot_ap_start[i]) begin
                    slot_ap_ready[i] = 1'b1;
                    slot_ap_done[i]  = (lat[i] == 0);
                    rcnt[i]          = (lat[i] == 0) ? -1 : lat[i];
                end else begin
                    slot_ap_ready[i] = 1'b0;
                    slot_ap_done[i]  = 1'b0;
                    if (rcnt[i] > 0) begin
                        rcnt[i]--;
                        if (rcnt[i] == 0) begin
                            slot_ap_done[i] = 1'b1;
                            rcnt[i]         = -1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic begin_job(input logic [CW-1:0] cnt, input logic [NS-1:0] m);
        tick();
        cyc       = 0;
        done_cyc  = -1;
        ready_mis = 0;
        for (int i = 0; i < NS; i++) begin
            start_cnt[i]    = 0;
            second_start[i] = -1;
            rcnt[i]         = -1;
        end
        slot_ap_ready = '0;
        slot_ap_done  = '0;
        run_count     = cnt;
        slot_mask     = m;
        ap_start      = 1'b1;
    endtask

    initial begin
        ap_rst        = 1'b1;
        ap_start      = 1'b0;
        run_count     = '0;
        slot_mask     = '0;
        slot_ap_ready = '0;
        slot_ap_done  = '0;
        slot_ap_idle  = '1;
        auto_resp     = 1'b0;
        cyc           = 0;
        done_cyc      = -1;
        ready_mis     = 0;
        for (int i = 0; i < NS; i++) begin
            start_cnt[i] = 0; second_start[i] = -1; lat[i] = 0; rcnt[i] = -1;
        end

        #1;
        chk("rst_idle", 32'(ap_idle), 1);
        chk("rst_done", 32'(ap_done), 0);
        chk("rst_ready", 32'(ap_ready), 0);
        chk("rst_slot_start", 32'(slot_ap_start), 0);
        chk("rst_runs", runs_done, 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        // count 1, all slots, ready&done together in cycle 5
        //             start rdy     dn      sstart  done  idle  runs
        tbl[0] = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 0};
        tbl[1] = '{1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, 0};
        tbl[2] = '{1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, 0};
        tbl[3] = '{1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, 0};
        tbl[4] = '{1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, 0};
        tbl[5] = '{1'b0, 3'b111, 3'b111, 3'b111, 1'b0, 1'b0, 0};
        tbl[6] = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 0};
        tbl[7] = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1};
        tbl[8] = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1};
        run_count = 1;
        slot_mask = 3'b111;
        for (int r = 0; r < 9; r++) begin
            tick();
            chk($sformatf("t1_c%0d_slot_start", r), 32'(slot_ap_start), 32'(tbl[r].e_sstart));
            chk($sformatf("t1_c%0d_done", r), 32'(ap_done), 32'(tbl[r].e_done));
            chk($sformatf("t1_c%0d_ready", r), 32'(ap_ready), 32'(tbl[r].e_done));
            chk($sformatf("t1_c%0d_idle", r), 32'(ap_idle), 32'(tbl[r].e_idle));
            chk($sformatf("t1_c%0d_runs", r), runs_done, tbl[r].e_runs);
            ap_start      = tbl[r].start;
            slot_ap_ready = tbl[r].rdy;
            slot_ap_done  = tbl[r].dn;
        end

        // count 3, staggered dones at cycles 4, 9, 6; idle inputs deliberately low
        auto_resp    = 1'b1;
        slot_ap_idle = '0;
        lat[0] = 3; lat[1] = 8; lat[2] = 5;
        begin_job(3, 3'b111);
        tick();
        ap_start = 1'b0;
        run_ticks(38);
        chk("t2_done_cycle", 32'(done_cyc), 31);
        chk("t2_runs_at_done", runs_at_done, 3);
        for (int i = 0; i < NS; i++) begin
            chk($sformatf("t2_starts_s%0d", i), 32'(start_cnt[i]), 3);
            chk($sformatf("t2_relaunch_cyc_s%0d", i), 32'(second_start[i]), 11);
        end
        chk("t2_idle_after", 32'(ap_idle), 1);
        chk("t2_ready_eq_done", 32'(ready_mis), 0);
        slot_ap_idle = '1;

        // mask 010, count 2; later mask/count edits must be ignored
        lat[0] = 5; lat[1] = 2; lat[2] = 5;
        begin_job(2, 3'b010);
        tick();
        ap_start  = 1'b0;
        slot_mask = 3'b111;
        run_count = 9;
        run_ticks(20);
        chk("t3_done_cycle", 32'(done_cyc), 9);
        chk("t3_runs_at_done", runs_at_done, 2);
        chk("t3_starts_s0", 32'(start_cnt[0]), 0);
        chk("t3_starts_s1", 32'(start_cnt[1]), 2);
        chk("t3_starts_s2", 32'(start_cnt[2]), 0);

        // degenerate starts
        begin_job(0, 3'b111);
        tick();
        ap_start = 1'b0;
        run_ticks(5);
        chk("t4a_done_cycle", 32'(done_cyc), 1);
        chk("t4a_runs", runs_at_done, 0);
        chk("t4a_no_start", 32'(start_cnt[0] + start_cnt[1] + start_cnt[2]), 0);
        chk("t4a_ready_eq_done", 32'(ready_mis), 0);
        begin_job(2, 3'b000);
        tick();
        ap_start = 1'b0;
        run_ticks(5);
        chk("t4b_done_cycle", 32'(done_cyc), 1);
        chk("t4b_no_start", 32'(start_cnt[0] + start_cnt[1] + start_cnt[2]), 0);

        // reset during iteration 2, then a clean job
        lat[0] = 2; lat[1] = 2; lat[2] = 2;
        begin_job(3, 3'b111);
        tick();
        ap_start = 1'b0;
        run_ticks(4);
        chk("t5_iter2_start", 32'(slot_ap_start), 32'(3'b111));
        chk("t5_iter2_runs", runs_done, 1);
        #1 ap_rst = 1'b1;
        #1;
        chk("t5_rst_slot_start", 32'(slot_ap_start), 0);
        chk("t5_rst_idle", 32'(ap_idle), 1);
        chk("t5_rst_runs", runs_done, 0);
        tick();
        ap_rst = 1'b0;
        lat[0] = 1; lat[1] = 1; lat[2] = 1;
        begin_job(1, 3'b111);
        tick();
        ap_start = 1'b0;
        run_ticks(8);
        chk("t5_new_done_cycle", 32'(done_cyc), 4);
        chk("t5_new_runs", runs_at_done, 1);
        chk("t5_new_starts_s2", 32'(start_cnt[2]), 1);

        // ap_start held high: ignored in RUN/FINISH, re-accepted in IDLE
        lat[0] = 0; lat[1] = 0; lat[2] = 0;
        begin_job(1, 3'b111);
        run_ticks(7);
        ap_start = 1'b0;
        run_ticks(8);
        chk("t6_first_done", 32'(done_cyc), 3);
        chk("t6_second_start", 32'(second_start[0]), 5);
        chk("t6_starts_s0", 32'(start_cnt[0]), 2);

`ifdef SLOT_SCHED_WATCHDOG_EN
        // slot 2 never completes
        lat[0] = 2; lat[1] = 2; lat[2] = -1;
        begin_job(1, 3'b111);
        tick();
        ap_start = 1'b0;
        run_ticks(25);
        chk("wd_done_cycle", 32'(done_cyc), 17);
        chk("wd_timeout_err", 32'(timeout_err), 1);
        chk("wd_slots_quiet", 32'(slot_ap_start), 0);
        chk("wd_idle", 32'(ap_idle), 1);
        begin_job(0, 3'b111);
        tick();
        ap_start = 1'b0;
        chk("wd_err_cleared", 32'(timeout_err), 0);
        run_ticks(4);
`else
        chk("no_wd_timeout_err", 32'(timeout_err), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
